// File: rtl/envelope_sequencer.sv
// ADSR envelope controller: steps a 16-bit envelope on each sample strobe and
// scales voice samples by envelope x velocity. Optional: ENVSEQ_VELOCITY_EN.
module envelope_sequencer (
  input  logic        inClk,
  input  logic        inReset,
  input  logic [11:0] inSample,
  input  logic        inSampleReady,
  input  logic        inIsPlaying,
  input  logic [6:0]  inVelocity,
  input  logic [7:0]  inAttackRate,
  input  logic [7:0]  inDecayRate,
  input  logic [7:0]  inSustainLevel,
  input  logic [7:0]  inReleaseRate,
  output logic [11:0] outSample,
  output logic        outSampleReady,
  output logic [15:0] outEnvelope,
  output logic [2:0]  outState,
  output logic        outActive
);

  // Handshake: inSampleReady/outSampleReady are single-cycle strobes with no
  // backpressure; every strobe in produces exactly one strobe out 2 cycles later.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } envStateT;

  envStateT state, stateNext;
  logic [15:0] env, envNext;
  logic        loadVel;
  logic [6:0]  gainVel;

  logic [15:0] stepAttack, stepDecay, stepRelease, target;
  logic [16:0] attackSum, decayLimit;

  assign stepAttack  = {4'h0, inAttackRate, 4'hF};
  assign stepDecay   = {4'h0, inDecayRate, 4'hF};
  assign stepRelease = {4'h0, inReleaseRate, 4'hF};
  assign target      = {inSustainLevel, inSustainLevel};
  assign attackSum   = {1'b0, env} + {1'b0, stepAttack};
  assign decayLimit  = {1'b0, target} + {1'b0, stepDecay};

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      state <= IDLE;
      env   <= 16'h0000;
    end else begin
      state <= stateNext;
      env   <= envNext;
    end
  end

  // Gate overrides take priority and leave the envelope untouched.
  always_comb begin
    stateNext = state;
    envNext   = env;
    loadVel   = 1'b0;
    if (inSampleReady) begin
      case (state)
        IDLE: begin
          if (inIsPlaying) begin
            stateNext = ATTACK;
            loadVel   = 1'b1;
          end else begin
            envNext = 16'h0000;
          end
        end
        ATTACK: begin
          if (!inIsPlaying) begin
            stateNext = RELEASE;
          end else if (attackSum >= 17'h0FFFF) begin
            envNext   = 16'hFFFF;
            stateNext = DECAY;
          end else begin
            envNext = attackSum[15:0];
          end
        end
        DECAY: begin
          if (!inIsPlaying) begin
            stateNext = RELEASE;
          end else if ({1'b0, env} <= decayLimit) begin
            envNext   = target;
            stateNext = SUSTAIN;
          end else begin
            envNext = env - stepDecay;
          end
        end
        SUSTAIN: begin
          if (!inIsPlaying) begin
            stateNext = RELEASE;
          end else begin
            envNext = target;
          end
        end
        RELEASE: begin
          if (inIsPlaying) begin
            stateNext = ATTACK;
            loadVel   = 1'b1;
          end else if (env <= stepRelease) begin
            envNext   = 16'h0000;
            stateNext = IDLE;
          end else begin
            envNext = env - stepRelease;
          end
        end
        default: begin
          stateNext = IDLE;
          envNext   = 16'h0000;
        end
      endcase
    end
  end

`ifdef ENVSEQ_VELOCITY_EN
  logic [6:0] velocity;

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      velocity <= 7'd0;
    end else if (loadVel) begin
      velocity <= inVelocity;
    end
  end

  assign gainVel = velocity;
`else
  logic unusedVelocity;

  assign unusedVelocity = ^{inVelocity, loadVel};
  assign gainVel        = 7'd127;
`endif

  // Gain is built from the pre-update envelope so it lines up with this strobe.
  logic [14:0] gain;
  assign gain = {7'd0, env[15:8]} * {8'd0, gainVel};

  logic [11:0] sampleQ;
  logic [14:0] gainQ;
  logic        validQ;

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      sampleQ <= 12'h000;
      gainQ   <= 15'd0;
      validQ  <= 1'b0;
    end else begin
      validQ <= inSampleReady;
      if (inSampleReady) begin
        sampleQ <= inSample;
        gainQ   <= gain;
      end
    end
  end

  logic signed [27:0] product, shifted;
  logic [15:0]        unusedShiftHigh;

  assign product         = $signed({{16{sampleQ[11]}}, sampleQ}) * $signed({13'd0, gainQ});
  assign shifted         = product >>> 15;
  assign unusedShiftHigh = shifted[27:12];

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset) begin
      outSample      <= 12'h000;
      outSampleReady <= 1'b0;
    end else begin
      outSampleReady <= validQ;
      if (validQ) begin
        outSample <= shifted[11:0];
      end
    end
  end

  assign outEnvelope = env;
  assign outState    = state;
  assign outActive   = (state != IDLE);

endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer: ADSR walk, scaling, retrigger and reset.
module tb_envelope_sequencer;

  logic        inClk;
  logic        inReset;
  logic [11:0] inSample;
  logic        inSampleReady;
  logic        inIsPlaying;
  logic [6:0]  inVelocity;
  logic [7:0]  inAttackRate;
  logic [7:0]  inDecayRate;
  logic [7:0]  inSustainLevel;
  logic [7:0]  inReleaseRate;
  logic [11:0] outSample;
  logic        outSampleReady;
  logic [15:0] outEnvelope;
  logic [2:0]  outState;
  logic        outActive;

  int vectors = 0;
  int miscompares = 0;

  // 2047 * gain >> 15 with env[15:8]=0x40: gain 0x40*64 or 0x40*127.
`ifdef ENVSEQ_VELOCITY_EN
  localparam logic [15:0] RETRIG_EXP = 16'h00FF;
`else
  localparam logic [15:0] RETRIG_EXP = 16'h01FB;
`endif

  envelope_sequencer dut (
    .inClk          (inClk),
    .inReset        (inReset),
    .inSample       (inSample),
    .inSampleReady  (inSampleReady),
    .inIsPlaying    (inIsPlaying),
    .inVelocity     (inVelocity),
    .inAttackRate   (inAttackRate),
    .inDecayRate    (inDecayRate),
    .inSustainLevel (inSustainLevel),
    .inReleaseRate  (inReleaseRate),
    .outSample      (outSample),
    .outSampleReady (outSampleReady),
    .outEnvelope    (outEnvelope),
    .outState       (outState),
    .outActive      (outActive)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One strobe cycle; returns 1 time unit after the capturing edge.
  task automatic strobe(input logic gate, input logic [11:0] sample);
    @(negedge inClk);
    inIsPlaying   = gate;
    inSample      = sample;
    inSampleReady = 1'b1;
    @(posedge inClk);
    #1;
  endtask

  task automatic idleCycle();
    @(negedge inClk);
    inSampleReady = 1'b0;
    @(posedge inClk);
    #1;
  endtask

  initial begin
    inReset        = 1'b1;
    inSample       = 12'h000;
    inSampleReady  = 1'b0;
    inIsPlaying    = 1'b0;
    inVelocity     = 7'd127;
    inAttackRate   = 8'hFF;
    inDecayRate    = 8'hFF;
    inSustainLevel = 8'h80;
    inReleaseRate  = 8'hFF;

    // Reset state
    repeat (3) @(posedge inClk);
    #1;
    check("rst_sample", outSample, 16'h0);
    check("rst_ready", outSampleReady, 16'h0);
    check("rst_env", outEnvelope, 16'h0);
    check("rst_state", outState, 16'h0);
    check("rst_active", outActive, 16'h0);
    @(negedge inClk);
    inReset = 1'b0;

    // Envelope at zero scales everything to zero
    strobe(1'b0, 12'h7FF);
    check("idle_state", outState, 16'h0);
    idleCycle();
    check("idle_out_ready", outSampleReady, 16'h1);
    check("idle_out_zero", outSample, 16'h0);
    idleCycle();

    // Attack
    strobe(1'b1, 12'h000);
    check("atk1_state", outState, 16'h1);
    check("atk1_env", outEnvelope, 16'h0);
    check("atk1_active", outActive, 16'h1);
    for (int i = 0; i < 16; i++) strobe(1'b1, 12'h000);
    check("atk17_env", outEnvelope, 16'hFFF0);
    check("atk17_state", outState, 16'h1);
    strobe(1'b1, 12'h000);
    check("atk18_env", outEnvelope, 16'hFFFF);
    check("atk18_state", outState, 16'h2);

    // Decay to sustain, live sustain change
    for (int i = 0; i < 7; i++) strobe(1'b1, 12'h000);
    check("dec7_env", outEnvelope, 16'h9006);
    check("dec7_state", outState, 16'h2);
    strobe(1'b1, 12'h000);
    check("dec8_env", outEnvelope, 16'h8080);
    check("dec8_state", outState, 16'h3);
    inSustainLevel = 8'h40;
    strobe(1'b1, 12'h000);
    check("sus40_env", outEnvelope, 16'h4040);
    inSustainLevel = 8'h80;
    strobe(1'b1, 12'h000);
    check("sus80_env", outEnvelope, 16'h8080);

    // Release
    strobe(1'b0, 12'h000);
    check("rel_ovr_state", outState, 16'h4);
    check("rel_ovr_env", outEnvelope, 16'h8080);
    for (int i = 0; i < 8; i++) strobe(1'b0, 12'h000);
    check("rel8_env", outEnvelope, 16'h0088);
    check("rel8_state", outState, 16'h4);
    strobe(1'b0, 12'h000);
    check("rel_end_env", outEnvelope, 16'h0);
    check("rel_end_state", outState, 16'h0);
    check("rel_end_active", outActive, 16'h0);

    // Full-scale envelope with velocity 127
    inSustainLevel = 8'hFF;
    strobe(1'b1, 12'h000);
    for (int i = 0; i < 17; i++) strobe(1'b1, 12'h000);
    check("full_atk_env", outEnvelope, 16'hFFFF);
    strobe(1'b1, 12'h000);
    check("full_sus_state", outState, 16'h3);
    check("full_sus_env", outEnvelope, 16'hFFFF);
    strobe(1'b1, 12'h7FF);
    strobe(1'b1, 12'h800);
    check("scale_pos_ready", outSampleReady, 16'h1);
    check("scale_pos", outSample, 16'h07E7);
    idleCycle();
    check("scale_neg_ready", outSampleReady, 16'h1);
    check("scale_neg", outSample, 16'h0817);
    idleCycle();
    check("scale_done_ready", outSampleReady, 16'h0);

    // Release down to 0x4000, then retrigger with velocity 64
    strobe(1'b0, 12'h000);
    check("rt_rel_state", outState, 16'h4);
    inReleaseRate = 8'hB4;
    for (int i = 0; i < 16; i++) strobe(1'b0, 12'h000);
    inReleaseRate = 8'hB0;
    strobe(1'b0, 12'h000);
    check("rt_rel_env", outEnvelope, 16'h4000);
    inVelocity = 7'd64;
    strobe(1'b1, 12'h000);
    check("rt_state", outState, 16'h1);
    check("rt_env", outEnvelope, 16'h4000);
    inAttackRate = 8'h00;
    strobe(1'b1, 12'h7FF);
    check("rt_env_step", outEnvelope, 16'h400F);
    idleCycle();
    check("rt_out_ready", outSampleReady, 16'h1);
    check("rt_out", outSample, RETRIG_EXP);

    // Reset mid-release with a sample in flight
    strobe(1'b0, 12'h000);
    strobe(1'b0, 12'h7FF);
    check("mid_rel_env", outEnvelope, 16'h3500);
    inSampleReady = 1'b0;
    #2;
    inReset = 1'b1;
    #1;
    check("mid_rst_sample", outSample, 16'h0);
    check("mid_rst_ready", outSampleReady, 16'h0);
    check("mid_rst_env", outEnvelope, 16'h0);
    check("mid_rst_state", outState, 16'h0);
    check("mid_rst_active", outActive, 16'h0);
    repeat (2) @(posedge inClk);
    @(negedge inClk);
    inReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge inClk);
      #1;
      check("post_rst_ready", outSampleReady, 16'h0);
      check("post_rst_state", outState, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
